instr_fetch: RTL and testbench
==============================

# instr_fetch

Program sequencer feeding the instruction decoder. Reads 21-bit instructions from a synchronous 1-cycle-latency program ROM and presents them one per cycle over a valid/ready handshake. Handles branch redirects and stops on the HALT opcode. Sits between the program ROM and the decoder; stalls when the decoder/I2C path deasserts ready.

## Interface
- ADDR_W, 8, program counter / ROM address width
- INSTR_W, 21, instruction width; opcode is bits [INSTR_W-1:INSTR_W-5]
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  asynchronous reset, active-high
- i_start  in  1  pulse; begin fetching at address 0 from IDLE or HALT
- o_rom_en  out  1  ROM read strobe
- o_rom_addr  out  ADDR_W  ROM read address
- i_rom_data  in  INSTR_W  ROM data, valid the cycle after o_rom_en
- o_instr  out  INSTR_W  instruction to decoder
- o_pc  out  ADDR_W  address of o_instr
- o_instr_valid  out  1  o_instr/o_pc valid
- i_instr_ready  in  1  decoder accepts; transfer when valid && ready
- i_branch_valid  in  1  redirect request
- i_branch_target  in  ADDR_W  redirect address
- o_halted  out  1  high in HALT state

## Operation
- States: IDLE (reset), RUN, HALT.
- IDLE: no fetches; i_start -> RUN with pc=0.
- RUN: 2-entry instruction buffer (instr + pc) plus at most 1 in-flight ROM read.
  - Issue a fetch (o_rom_en=1, o_rom_addr=pc, pc<=pc+1) when occupancy + in_flight - pop < 2, where pop = o_instr_valid && i_instr_ready.
  - Returning data is pushed with its fetch address the cycle after issue.
  - Output is the buffer head; o_instr_valid = buffer non-empty.
  - pc wraps 255 -> 0 with no flag.
- Branch (i_branch_valid in RUN):
  - Flush the buffer and mark any in-flight read discard; its data is dropped next cycle.
  - pc <= i_branch_target.
  - Branch wins over a simultaneous pop or push.
  - Fetch of the target issues the following cycle.
  - Ignored in IDLE and HALT.
- HALT opcode 5'b11111:
  - When returning data carries it, it is not pushed and no further fetches issue.
  - Already-buffered instructions still drain.
  - Enter HALT once the buffer is empty.
  - A branch before the buffer empties cancels the halt and stays in RUN.
- HALT: o_halted=1; i_start -> RUN at pc=0.
- i_start while in RUN is ignored.
- Reset mid-operation: everything cleared immediately; ROM data returning after reset is ignored.

## Timing
- Reset values:
  - o_rom_en=0, o_rom_addr=0, o_instr=0, o_pc=0, o_instr_valid=0, o_halted=0.
  - State IDLE, pc=0, buffer empty, no in-flight read.
- Start latency: i_start sampled at edge 0; o_rom_en for addr 0 during cycle 1; data captured at edge 2; o_instr_valid high in cycle 3.
- Throughput: one instruction per cycle with i_instr_ready held high.
- Branch penalty: branch sampled at edge B; target fetch in cycle B+1; target instruction valid in cycle B+3; o_instr_valid low in cycles B+1..B+2.
- Stall: o_instr/o_pc hold stable while valid && !ready. ROM reads stop once 2 entries are committed; no data is ever lost.
- o_rom_addr holds its last value when o_rom_en=0.

## Configuration
- FETCH_HALT_EN defined: HALT opcode detection and the HALT state as above.
- Undefined: 5'b11111 is passed to the decoder as an ordinary instruction, HALT is never entered, o_halted is tied 0, and i_start is honoured only in IDLE.

## Test plan
- Reset then i_start, ROM[0..3]=A,B,C,D, ready=1 -> A/pc0 valid in cycle 3, then B, C, D on consecutive cycles, o_rom_en continuous.
- Ready low 5 cycles after first transfer -> o_instr/o_pc frozen, at most 2 reads issued during stall, sequence resumes with no gap, loss or duplicate.
- Branch to 0x40 while ROM[5] in flight and 2 entries buffered -> buffered/in-flight entries never presented; next valid is pc 0x40 exactly 3 cycles after the branch.
- ROM[0xFE..0x01] sequential -> pc sequence FE, FF, 00, 01.
- FETCH_HALT_EN, ROM[2]=5'b11111 opcode -> pcs 0,1 delivered, o_halted=1 after drain, no o_rom_en after ROM[2] data returns; i_start restarts at pc 0.
- Assert i_rst with a read in flight -> all outputs at reset values immediately; stale i_rom_data never appears on o_instr.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: program sequencer between the 1-cycle-latency program ROM and the decoder.
// Define FETCH_HALT_EN to enable HALT opcode (5'b11111) detection and the HALT state.
module instr_fetch #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 21
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    output logic               o_rom_en,
    output logic [ADDR_W-1:0]  o_rom_addr,
    input  logic [INSTR_W-1:0] i_rom_data,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_instr_valid,
    input  logic               i_instr_ready,
    input  logic               i_branch_valid,
    input  logic [ADDR_W-1:0]  i_branch_target,
    output logic               o_halted
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc, pc_nxt;
    logic [ADDR_W-1:0]  last_addr;
    logic [INSTR_W-1:0] buf_instr     [2];
    logic [INSTR_W-1:0] buf_instr_nxt [2];
    logic [ADDR_W-1:0]  buf_pc        [2];
    logic [ADDR_W-1:0]  buf_pc_nxt    [2];
    logic [1:0]         count, count_nxt;
    logic               inflight;
    logic               halt_pending, halt_pending_nxt;
    logic               pop, branch, halt_seen, fetch, push;
    logic [2:0]         occ;

    assign pop    = (count != 2'd0) && i_instr_ready;
    assign branch = (state == RUN) && i_branch_valid;
    assign occ    = {1'b0, count} + {2'b00, inflight};

    // last_addr doubles as the address of the read currently returning
`ifdef FETCH_HALT_EN
    assign halt_seen = inflight && (i_rom_data[INSTR_W-1 -: 5] == 5'b11111);
`else
    assign halt_seen = 1'b0;
`endif

    always_comb begin
        state_nxt        = state;
        pc_nxt           = pc;
        count_nxt        = count;
        buf_instr_nxt    = buf_instr;
        buf_pc_nxt       = buf_pc;
        halt_pending_nxt = halt_pending;
        fetch            = 1'b0;
        push             = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                end
            end
`ifdef FETCH_HALT_EN
            HALT: begin
                if (i_start) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                end
            end
`endif
            RUN: begin
                if (branch) begin
                    // returning data this cycle is simply not pushed
                    pc_nxt           = i_branch_target;
                    count_nxt        = '0;
                    halt_pending_nxt = 1'b0;
                end else begin
                    fetch = !halt_pending && !halt_seen && (occ < (3'd2 + {2'b00, pop}));
                    if (fetch) begin
                        pc_nxt = pc + PC_ONE;
                    end
                    if (pop) begin
                        buf_instr_nxt[0] = buf_instr[1];
                        buf_pc_nxt[0]    = buf_pc[1];
                        count_nxt        = count - 2'd1;
                    end
                    push = inflight && !halt_seen;
                    if (push) begin
                        buf_instr_nxt[count_nxt[0]] = i_rom_data;
                        buf_pc_nxt[count_nxt[0]]    = last_addr;
                        count_nxt                   = count_nxt + 2'd1;
                    end
`ifdef FETCH_HALT_EN
                    if (halt_seen) begin
                        halt_pending_nxt = 1'b1;
                    end
                    if (halt_pending_nxt && (count_nxt == 2'd0)) begin
                        state_nxt        = HALT;
                        halt_pending_nxt = 1'b0;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            pc           <= '0;
            last_addr    <= '0;
            inflight     <= 1'b0;
            count        <= '0;
            halt_pending <= 1'b0;
            buf_instr[0] <= '0;
            buf_instr[1] <= '0;
            buf_pc[0]    <= '0;
            buf_pc[1]    <= '0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            inflight     <= fetch;
            count        <= count_nxt;
            halt_pending <= halt_pending_nxt;
            buf_instr    <= buf_instr_nxt;
            buf_pc       <= buf_pc_nxt;
            if (fetch) begin
                last_addr <= pc;
            end
        end
    end

    assign o_rom_en      = fetch;
    assign o_rom_addr    = fetch ? pc : last_addr;
    assign o_instr       = buf_instr[0];
    assign o_pc          = buf_pc[0];
    assign o_instr_valid = (count != 2'd0);
`ifdef FETCH_HALT_EN
    assign o_halted      = (state == HALT);
`else
    assign o_halted      = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected program-order stream queued at start/branch, monitor compares.
`timescale 1ns/1ps
module tb_instr_fetch;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 21;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_start;
    logic               o_rom_en;
    logic [ADDR_W-1:0]  o_rom_addr;
    logic [INSTR_W-1:0] i_rom_data = '0;
    logic [INSTR_W-1:0] o_instr;
    logic [ADDR_W-1:0]  o_pc;
    logic               o_instr_valid;
    logic               i_instr_ready;
    logic               i_branch_valid;
    logic [ADDR_W-1:0]  i_branch_target;
    logic               o_halted;

    instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .o_rom_en(o_rom_en), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
        .o_instr(o_instr), .o_pc(o_pc), .o_instr_valid(o_instr_valid),
        .i_instr_ready(i_instr_ready), .i_branch_valid(i_branch_valid),
        .i_branch_target(i_branch_target), .o_halted(o_halted)
    );

    always #5 i_clk = ~i_clk;

    // synchronous program ROM, one cycle of read latency
    logic [INSTR_W-1:0] rom [256];
    always @(posedge i_clk) if (o_rom_en) i_rom_data <= rom[o_rom_addr];

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } exp_t;

    exp_t              exp_q[$];
    int                n_checks = 0;
    int                n_fail = 0;
    bit                model_run = 0, model_halted = 0, halt_read = 0;
    bit                flush_now = 0, ev_arm = 0;
    logic [ADDR_W-1:0] fetch_addr = '0, last_addr = '0, ev_pc = '0;
    int                issued = 0, delivered = 0, ev = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_halt(input logic [INSTR_W-1:0] w);
        bit en = 1'b0;
`ifdef FETCH_HALT_EN
        en = 1'b1;
`endif
        return en && (w[INSTR_W-1 -: 5] == 5'b11111);
    endfunction

    function automatic logic [INSTR_W-1:0] rand_word();
        logic [INSTR_W-1:0] w;
        w = INSTR_W'($urandom);
        if (w[INSTR_W-1 -: 5] == 5'b11111) w[INSTR_W-1] = 1'b0;
        return w;
    endfunction

    // program order from address a: sequential words, ending before a HALT opcode
    task automatic flush(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] p;
        exp_t e;
        exp_q.delete();
        p = a;
        for (int i = 0; i < 512; i++) begin
            if (is_halt(rom[p])) break;
            e.instr = rom[p];
            e.pc    = p;
            exp_q.push_back(e);
            p = p + 8'd1;
        end
        fetch_addr = a; issued = 0; delivered = 0; halt_read = 0;
        flush_now = 1; ev_arm = 1; ev_pc = a;
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_run = 0; model_halted = 0; halt_read = 0; flush_now = 0; ev_arm = 0;
        ev = -1; last_addr = '0; fetch_addr = '0; issued = 0; delivered = 0;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_start();
        i_start = 1'b1;
        if (!model_run) begin
            model_run = 1; model_halted = 0;
            flush('0);
        end
        step();
        i_start = 1'b0;
    endtask

    task automatic do_branch(input logic [ADDR_W-1:0] t);
        i_branch_valid  = 1'b1;
        i_branch_target = t;
        if (model_run) flush(t);
        step();
        i_branch_valid = 1'b0;
    endtask

    task automatic reset_dut();
        i_rst = 1'b1;
        model_reset();
        step();
        i_rst = 1'b0;
        step();
    endtask

    task automatic wait_halt();
        int n = 0;
        while (!o_halted && n < 30) begin
            step();
            n++;
        end
        chk("halt_reached", o_halted, 1);
        chk("halt_deliveries", delivered, 2);
        step();
        step();
    endtask

    // monitor: samples on the falling edge, compares against the queued program order
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (flush_now) begin
                chk("flush_cycle_no_fetch", o_rom_en, 0);
                flush_now = 0;
            end else if (!model_run) begin
                chk("idle_no_fetch", o_rom_en, 0);
                chk("idle_no_valid", o_instr_valid, 0);
                chk("idle_addr_hold", o_rom_addr, last_addr);
                chk("halted_flag", o_halted, model_halted);
            end else begin
                if (ev >= 0) ev++;
                if (ev == 1 || ev == 2) chk("redirect_bubble", o_instr_valid, 0);
                if (ev == 1) chk("redirect_first_fetch", o_rom_en, 1);
                if (ev == 3) begin
                    chk("redirect_latency", o_instr_valid, exp_q.size() != 0);
                    if (o_instr_valid) chk("redirect_pc", o_pc, ev_pc);
                    ev = -1;
                end
                if (o_rom_en) begin
                    chk("rom_addr", o_rom_addr, fetch_addr);
                    chk("fetch_after_halt", halt_read, 0);
                    if (is_halt(rom[fetch_addr])) halt_read = 1;
                    last_addr = fetch_addr;
                    fetch_addr = fetch_addr + 8'd1;
                    issued++;
                end else begin
                    chk("rom_addr_hold", o_rom_addr, last_addr);
                end
                if (o_instr_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", o_instr_valid, 0);
                    end else begin
                        chk("instr", o_instr, exp_q[0].instr);
                        chk("pc", o_pc, exp_q[0].pc);
                        if (i_instr_ready) begin
                            void'(exp_q.pop_front());
                            delivered++;
                        end
                    end
                end
                chk("read_limit", (issued - delivered) <= 2, 1);
                if (o_halted) begin
                    chk("halt_after_drain", (exp_q.size() == 0) && halt_read, 1);
                    model_run = 0;
                    model_halted = 1;
                end
            end
            if (ev_arm) begin
                ev = 0;
                ev_arm = 0;
            end
        end
    end

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_instr_ready = 1'b0;
        i_branch_valid = 1'b0; i_branch_target = '0;
        model_reset();
        for (int i = 0; i < 256; i++) rom[i] = rand_word();
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_rom_en", o_rom_en, 0);
        chk("rst_rom_addr", o_rom_addr, 0);
        chk("rst_instr", o_instr, 0);
        chk("rst_pc", o_pc, 0);
        chk("rst_valid", o_instr_valid, 0);
        chk("rst_halted", o_halted, 0);
        i_rst = 1'b0;
        step();

        // start latency and full-rate streaming
        i_instr_ready = 1'b1;
        do_start();
        chk("start_fetch_en", o_rom_en, 1);
        chk("start_fetch_addr", o_rom_addr, 0);
        step();
        chk("start_bubble", o_instr_valid, 0);
        step();
        chk("start_valid", o_instr_valid, 1);
        chk("start_pc", o_pc, 0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("stream_valid", o_instr_valid, 1);
            chk("stream_pc", o_pc, ADDR_W'(i));
            chk("stream_fetch", o_rom_en, 1);
        end

        // decoder stall, then resume with no gap
        i_instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_pc", o_pc, 3);
            step();
        end
        i_instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("resume_valid", o_instr_valid, 1);
            chk("resume_pc", o_pc, ADDR_W'(3 + i));
            step();
        end

        // branch with buffered entries and a read in flight
        i_instr_ready = 1'b0;
        repeat (3) step();
        i_instr_ready = 1'b1;
        step();
        do_branch(8'h40);
        chk("branch_bubble1", o_instr_valid, 0);
        step();
        chk("branch_bubble2", o_instr_valid, 0);
        step();
        chk("branch_valid", o_instr_valid, 1);
        chk("branch_pc", o_pc, 8'h40);

        // pc wrap
        do_branch(8'hFE);
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            logic [ADDR_W-1:0] p;
            p = 8'hFE + ADDR_W'(i);
            chk("wrap_valid", o_instr_valid, 1);
            chk("wrap_pc", o_pc, p);
            step();
        end

        // HALT opcode at address 2
        reset_dut();
        rom[2] = {5'b11111, 16'($urandom)};
        i_instr_ready = 1'b1;
        do_start();
`ifdef FETCH_HALT_EN
        wait_halt();
        do_start();
        wait_halt();
`else
        repeat (8) step();
        chk("no_halt", o_halted, 0);
        do_start();
        repeat (4) step();
`endif
        reset_dut();
        rom[2] = rand_word();

        // reset with a read in flight
        do_start();
        repeat (5) step();
        i_rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_rom_en", o_rom_en, 0);
        chk("midrst_rom_addr", o_rom_addr, 0);
        chk("midrst_instr", o_instr, 0);
        chk("midrst_pc", o_pc, 0);
        chk("midrst_valid", o_instr_valid, 0);
        chk("midrst_halted", o_halted, 0);
        step();
        i_rst = 1'b0;
        repeat (3) step();
        chk("post_rst_instr", o_instr, 0);
        do_start();
        repeat (10) step();

        // randomized ready, branches and ignored start pulses
        for (int c = 0; c < 400; c++) begin
            int unsigned r;
            r = $urandom_range(0, 63);
            i_instr_ready = ($urandom_range(0, 3) != 0);
            if (r < 4) do_branch(ADDR_W'($urandom));
            else if (r == 4) do_start();
            else step();
        end
        i_instr_ready = 1'b0;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
